// File: rtl/game_ctrl.sv
// Tic-tac-toe referee: owns the board, alternates move requests between the
// FPGA move generator (X) and the user (O), rejects illegal moves, reports results.
module game_ctrl #(
  parameter bit FPGA_FIRST = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_newgame,
  output logic [17:0] o_board,
  output logic [1:0]  o_result,
  output logic        o_isdraw,
  output logic        o_result_stb,
  output logic        o_needinput,
  input  logic        i_busy,
  input  logic [3:0]  i_move,
  input  logic        i_validmove_stb,
  output logic        o_fpga_req,
  input  logic [3:0]  i_fpga_move,
  input  logic        i_fpga_move_stb
);

  typedef enum logic [2:0] {
    START   = 3'd0,
    X_WAIT  = 3'd1,
    X_CHECK = 3'd2,
    O_WAIT  = 3'd3,
    O_CHECK = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [1:0] MARK_O = 2'b01;
  localparam logic [1:0] MARK_X = 2'b10;

  state_t      state, state_nxt;
  logic [3:0]  mv_p0, mv_d;
  logic [3:0]  cnt_p0, cnt_d;
  logic        fin_p0, fin_d;
  logic [17:0] board_d;
  logic [1:0]  result_d;
  logic        isdraw_d;
  logic        fpga_req_d;
  logic        needinput_d;

  logic [1:0]  mark;
  logic        occupied;
  logic        legal;
  logic        win;
  logic [17:0] board_upd;
  logic [3:0]  cnt_inc;

  // Square n occupies bits [19-2n:18-2n], so square i+1 sits at [17-2i -: 2].
  function automatic logic line_win(input logic [17:0] b, input logic [1:0] m);
    logic [8:0] h;
    for (int i = 0; i < 9; i++) h[i] = (b[17-2*i -: 2] == m);
    return (h[0] & h[1] & h[2]) | (h[3] & h[4] & h[5]) | (h[6] & h[7] & h[8]) |
           (h[0] & h[3] & h[6]) | (h[1] & h[4] & h[7]) | (h[2] & h[5] & h[8]) |
           (h[0] & h[4] & h[8]) | (h[2] & h[4] & h[6]);
  endfunction

  // Latched move against the current board: legality and the post-move board.
  always_comb begin
    mark      = (state == X_CHECK) ? MARK_X : MARK_O;
    occupied  = 1'b0;
    board_upd = o_board;
    for (int i = 0; i < 9; i++) begin
      if (mv_p0 == 4'(i + 1)) begin
        occupied               = |o_board[17-2*i -: 2];
        board_upd[17-2*i -: 2] = mark;
      end
    end
    legal   = (mv_p0 >= 4'd1) && (mv_p0 <= 4'd9) && !occupied;
    win     = line_win(board_upd, mark);
    cnt_inc = cnt_p0 + 4'd1;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= START;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      START:   state_nxt = FPGA_FIRST ? X_WAIT : O_WAIT;
      X_WAIT:  if (i_fpga_move_stb) state_nxt = X_CHECK;
      O_WAIT:  if (i_validmove_stb) state_nxt = O_CHECK;
      X_CHECK: begin
        if (!legal)                 state_nxt = X_WAIT;
        else if (win)               state_nxt = DONE;
        else if (cnt_inc == 4'd9)   state_nxt = DONE;
        else                        state_nxt = O_WAIT;
      end
      O_CHECK: begin
        if (!legal)                 state_nxt = O_WAIT;
        else if (win)               state_nxt = DONE;
        else if (cnt_inc == 4'd9)   state_nxt = DONE;
        else                        state_nxt = X_WAIT;
      end
      DONE:    if (i_newgame) state_nxt = START;
      default: state_nxt = START;
    endcase
  end

  // Requests track the next state so they drop on the strobe edge and rise on the CHECK edge.
  always_comb begin
    board_d     = o_board;
    cnt_d       = cnt_p0;
    result_d    = o_result;
    isdraw_d    = o_isdraw;
    mv_d        = mv_p0;
    fpga_req_d  = (state != START) && (state_nxt == X_WAIT);
    needinput_d = (state != START) && (state_nxt == O_WAIT) && !i_busy;
    fin_d       = ((state == X_CHECK) || (state == O_CHECK)) && (state_nxt == DONE);
    case (state)
      START: begin
        board_d  = '0;
        cnt_d    = '0;
        result_d = 2'd0;
        isdraw_d = 1'b0;
      end
      X_WAIT: if (i_fpga_move_stb) mv_d = i_fpga_move;
      O_WAIT: if (i_validmove_stb) mv_d = i_move;
      X_CHECK, O_CHECK: begin
        if (legal) begin
          board_d = board_upd;
          cnt_d   = cnt_inc;
          if (win)                  result_d = (state == X_CHECK) ? 2'd1 : 2'd2;
          else if (cnt_inc == 4'd9) isdraw_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_board      <= '0;
      o_result     <= 2'd0;
      o_isdraw     <= 1'b0;
      o_result_stb <= 1'b0;
      o_needinput  <= 1'b0;
      o_fpga_req   <= 1'b0;
      mv_p0        <= '0;
      cnt_p0       <= '0;
      fin_p0       <= 1'b0;
    end else begin
      o_board      <= board_d;
      o_result     <= result_d;
      o_isdraw     <= isdraw_d;
      o_result_stb <= fin_p0;
      o_needinput  <= needinput_d;
      o_fpga_req   <= fpga_req_d;
      mv_p0        <= mv_d;
      cnt_p0       <= cnt_d;
      fin_p0       <= fin_d;
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: directed games plus random games (with illegal moves and
// busy gaps) checked against a square-array model of the rules.
module tb_game_ctrl;

  logic        i_clk;
  logic        i_reset;
  logic        i_newgame;
  logic [17:0] o_board;
  logic [1:0]  o_result;
  logic        o_isdraw;
  logic        o_result_stb;
  logic        o_needinput;
  logic        i_busy;
  logic [3:0]  i_move;
  logic        i_validmove_stb;
  logic        o_fpga_req;
  logic [3:0]  i_fpga_move;
  logic        i_fpga_move_stb;

  game_ctrl #(.FPGA_FIRST(1'b1)) dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_newgame       (i_newgame),
    .o_board         (o_board),
    .o_result        (o_result),
    .o_isdraw        (o_isdraw),
    .o_result_stb    (o_result_stb),
    .o_needinput     (o_needinput),
    .i_busy          (i_busy),
    .i_move          (i_move),
    .i_validmove_stb (i_validmove_stb),
    .o_fpga_req      (o_fpga_req),
    .i_fpga_move     (i_fpga_move),
    .i_fpga_move_stb (i_fpga_move_stb)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_bad = 0;

  // Model: mb[n] = 0 empty, 1 O, 2 X for squares 1..9.
  int mb [10];
  int mcnt;
  bit x_turn;
  bit game_over;
  int lines [8][3] = '{'{1,2,3}, '{4,5,6}, '{7,8,9}, '{1,4,7},
                       '{2,5,8}, '{3,6,9}, '{1,5,9}, '{3,5,7}};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [17:0] pack_board();
    logic [17:0] b;
    b = '0;
    for (int n = 1; n <= 9; n++) b[19-2*n -: 2] = 2'(mb[n]);
    return b;
  endfunction

  function automatic bit wins(input int m);
    for (int l = 0; l < 8; l++)
      if (mb[lines[l][0]] == m && mb[lines[l][1]] == m && mb[lines[l][2]] == m) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    for (int n = 0; n < 10; n++) mb[n] = 0;
    mcnt      = 0;
    x_turn    = 1'b1;
    game_over = 1'b0;
  endtask

  // Submit one move with the request already up; follows it through to the next request or the result.
  task automatic play(input bit is_x, input int sq, input bit hold2);
    int mk;
    bit legal;
    bit over;
    bit nxt_x;
    int exp_res;
    bit exp_draw;
    mk = is_x ? 2 : 1;
    exp_res = 0;
    exp_draw = 1'b0;
    if (is_x) begin
      chk("fpga_req_before", 32'(o_fpga_req), 1);
      i_fpga_move = 4'(sq);
      i_fpga_move_stb = 1'b1;
    end else begin
      chk("needin_before", 32'(o_needinput), 1);
      i_move = 4'(sq);
      i_validmove_stb = 1'b1;
    end
    @(posedge i_clk); #1;
    if (!hold2) begin
      i_fpga_move_stb = 1'b0;
      i_validmove_stb = 1'b0;
    end
    chk("req_drop", 32'({o_fpga_req, o_needinput}), 0);
    @(posedge i_clk); #1;
    i_fpga_move_stb = 1'b0;
    i_validmove_stb = 1'b0;
    legal = 1'b0;
    if (sq >= 1 && sq <= 9) legal = (mb[sq] == 0);
    if (legal) begin
      mb[sq] = mk;
      mcnt++;
    end
    chk("board", 32'(o_board), 32'(pack_board()));
    chk("stb_early", 32'(o_result_stb), 0);
    over = 1'b0;
    if (legal && wins(mk)) begin
      over = 1'b1;
      exp_res = is_x ? 1 : 2;
    end else if (legal && mcnt == 9) begin
      over = 1'b1;
      exp_draw = 1'b1;
    end
    if (!over) begin
      nxt_x = legal ? !is_x : is_x;
      chk("fpga_req_next", 32'(o_fpga_req), 32'(nxt_x));
      chk("needin_next", 32'(o_needinput), 32'(!nxt_x && !i_busy));
      x_turn = nxt_x;
    end else begin
      chk("req_done", 32'({o_fpga_req, o_needinput}), 0);
      @(posedge i_clk); #1;
      chk("result_stb", 32'(o_result_stb), 1);
      chk("result", 32'(o_result), 32'(exp_res));
      chk("isdraw", 32'(o_isdraw), 32'(exp_draw));
      chk("board_final", 32'(o_board), 32'(pack_board()));
      @(posedge i_clk); #1;
      chk("stb_once", 32'(o_result_stb), 0);
      chk("result_hold", 32'(o_result), 32'(exp_res));
      game_over = 1'b1;
    end
  endtask

  task automatic new_game();
    i_newgame = 1'b1;
    @(posedge i_clk); #1;
    i_newgame = 1'b0;
    chk("ng_stb", 32'(o_result_stb), 0);
    @(posedge i_clk); #1;
    chk("ng_board", 32'(o_board), 0);
    chk("ng_result", 32'(o_result), 0);
    chk("ng_isdraw", 32'(o_isdraw), 0);
    chk("ng_req_low", 32'({o_fpga_req, o_needinput}), 0);
    @(posedge i_clk); #1;
    chk("ng_fpga_req", 32'(o_fpga_req), 1);
    model_clear();
  endtask

  // Asynchronous reset mid-cycle, with a strobe thrown in that must be lost.
  task automatic do_reset();
    #2 i_reset = 1'b1;
    #1;
    chk("rst_board", 32'(o_board), 0);
    chk("rst_result", 32'(o_result), 0);
    chk("rst_isdraw", 32'(o_isdraw), 0);
    chk("rst_stb", 32'(o_result_stb), 0);
    chk("rst_reqs", 32'({o_fpga_req, o_needinput}), 0);
    i_fpga_move = 4'd5;
    i_fpga_move_stb = 1'b1;
    @(posedge i_clk); #1;
    i_fpga_move_stb = 1'b0;
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    @(posedge i_clk); #1;
    chk("start_req_low", 32'({o_fpga_req, o_needinput}), 0);
    chk("start_board", 32'(o_board), 0);
    @(posedge i_clk); #1;
    chk("start_fpga_req", 32'(o_fpga_req), 1);
    chk("start_needin", 32'(o_needinput), 0);
    model_clear();
  endtask

  function automatic int pick_move();
    int r;
    int q[$];
    r = int'($urandom_range(0, 3));
    if (r == 0) return ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(10, 15));
    if (r == 1) begin
      for (int n = 1; n <= 9; n++) if (mb[n] != 0) q.push_back(n);
      if (q.size() > 0) return q[$urandom_range(0, q.size() - 1)];
    end
    q.delete();
    for (int n = 1; n <= 9; n++) if (mb[n] == 0) q.push_back(n);
    return q[$urandom_range(0, q.size() - 1)];
  endfunction

  initial begin
    int d;
    bit bz;
    i_reset = 1'b0;
    i_newgame = 1'b0;
    i_busy = 1'b0;
    i_move = '0;
    i_validmove_stb = 1'b0;
    i_fpga_move = '0;
    i_fpga_move_stb = 1'b0;
    model_clear();
    do_reset();

    // X wins on the top row.
    play(1, 1, 0); play(0, 5, 0); play(1, 2, 0); play(0, 9, 0); play(1, 3, 0);
    chk("xwin_board_lit", 32'(o_board), 32'(18'b10_10_10_00_01_00_00_00_01));

    // O completes the middle row first.
    new_game();
    play(1, 1, 0); play(0, 4, 0); play(1, 2, 0); play(0, 5, 0); play(1, 9, 0); play(0, 6, 0);

    // Draw on a full board.
    new_game();
    play(1, 1, 0); play(0, 2, 0); play(1, 3, 0); play(0, 5, 0); play(1, 4, 0);
    play(0, 6, 0); play(1, 8, 0); play(0, 7, 0); play(1, 9, 0);

    // Illegal user moves, a doubled strobe, then busy holding off the request.
    new_game();
    play(1, 1, 0);
    play(0, 0, 0); play(0, 10, 0); play(0, 1, 0); play(0, 7, 0);
    play(1, 2, 0);
    play(0, 5, 1);
    chk("hold2_count", 32'(o_board), 32'(pack_board()));
    i_busy = 1'b1;
    play(1, 9, 0);
    for (int k = 0; k < 5; k++) begin
      @(posedge i_clk); #1;
      chk("busy_needin", 32'(o_needinput), 0);
    end
    i_busy = 1'b0;
    @(posedge i_clk); #1;
    chk("busy_release", 32'(o_needinput), 1);
    play(0, 3, 0);

    // Reset after four moves.
    new_game();
    play(1, 1, 0); play(0, 2, 0); play(1, 3, 0); play(0, 4, 0);
    do_reset();

    // Random games.
    for (int g = 0; g < 15; g++) begin
      while (!game_over) begin
        d = int'($urandom_range(0, 3));
        for (int k = 0; k < d; k++) begin
          bz = x_turn ? 1'b0 : 1'(($urandom_range(0, 1)));
          i_busy = bz;
          @(posedge i_clk); #1;
          if (x_turn) chk("rnd_fpga_req", 32'(o_fpga_req), 1);
          else        chk("rnd_needin", 32'(o_needinput), 32'(!bz));
        end
        if (i_busy) begin
          i_busy = 1'b0;
          @(posedge i_clk); #1;
        end
        play(x_turn, pick_move(), 1'($urandom_range(0, 1)));
      end
      new_game();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Tic-tac-toe referee and turn sequencer: the controller on the far side of the user I/O block. It owns the board, requests moves alternately from the FPGA move generator (X) and the user (O), and rejects illegal moves. After each placement it checks for a win or draw, then strobes the final result to the user I/O block.

## Interface
- FPGA_FIRST, default 1: 1 = X (FPGA) moves first after reset/new game; 0 = O (user) first.
- i_clk  in  1  global clock; one clock domain.
- i_reset  in  1  asynchronous, active-high reset.
- i_newgame  in  1  one-cycle pulse: clear board, restart; honoured only in DONE.
- o_board  out  18  square n (1..9) at bits [19-2n:18-2n]; 00 empty, 01 O, 10 X (11 never driven).
- o_result  out  2  0 none, 1 X wins, 2 O wins; valid with o_result_stb.
- o_isdraw  out  1  draw flag; valid with o_result_stb.
- o_result_stb  out  1  one-cycle pulse at game end.
- o_needinput  out  1  user move requested.
- i_busy  in  1  user I/O busy; suppresses o_needinput.
- i_move  in  4  user square; valid with i_validmove_stb.
- i_validmove_stb  in  1  one-cycle strobe: i_move valid.
- o_fpga_req  out  1  FPGA move requested.
- i_fpga_move  in  4  FPGA square; valid with i_fpga_move_stb.
- i_fpga_move_stb  in  1  one-cycle strobe: i_fpga_move valid.

## Operation
- States: START, X_WAIT, X_CHECK, O_WAIT, O_CHECK, DONE.
- START: board, 4-bit move count, o_result and o_isdraw cleared; next is X_WAIT if FPGA_FIRST, else O_WAIT.
- X_WAIT: o_fpga_req high. On i_fpga_move_stb, latch the square and go to X_CHECK.
- O_WAIT: o_needinput registered as !i_busy each cycle. On i_validmove_stb, latch i_move, clear o_needinput and go to O_CHECK. A strobe seen while in any other state is ignored.
- Legal move: value 1..9 and target square empty. i_move is the low nibble of an ASCII digit.
- Illegal move (0, 10..15, or an occupied square): board unchanged, return to the same WAIT state. This re-requests the move, so the user I/O block redisplays the board. A trailing newline (nibble 0xA) is rejected by this rule.
- X_CHECK/O_CHECK with a legal move:
  - Write the mark and increment the count.
  - Evaluate the 8 lines (3 rows, 3 columns, 2 diagonals) on the updated board, for the mover's mark only.
  - Win: o_result = 1 (X) or 2 (O), then DONE.
  - Else if count == 9: o_isdraw = 1, then DONE.
  - Else: go to the other side's WAIT state.
- A win on the 9th move reports the win, not a draw.
- Entering DONE: o_result_stb high for exactly one cycle, with o_board, o_result and o_isdraw already final. These outputs hold until i_newgame, which moves the block to START.
- i_reset at any time, including mid-handshake: all state and outputs return to reset values asynchronously. A strobe arriving during reset is lost.

## Timing
- Reset values: o_board 0, o_result 0, o_isdraw 0, o_result_stb 0, o_needinput 0, o_fpga_req 0; state START.
- All outputs are registered.
- After reset release: START occupies 1 cycle; the request output is high from the 2nd edge.
- Request drop: o_fpga_req and o_needinput fall on the edge that samples the strobe. The user block therefore never sees o_needinput high with its strobe low after a submitted move.
- Board update: visible on o_board 2 edges after the strobe (latch edge, CHECK edge).
- Next request: follows the CHECK edge directly, so the opposite request rises 2 edges after the strobe.
- Illegal move: the same request re-rises 2 edges after the strobe.
- o_result_stb: rises 1 edge after the CHECK edge, i.e. 3 edges after the final strobe.
- o_needinput never rises while i_busy is high; it follows i_busy low with one cycle of latency.

## Test plan
- Reset, FPGA_FIRST=1, X plays 1,2,3; O plays 5,9: o_result_stb pulses once, o_result=1, o_isdraw=0, o_board=18'b10_10_10_00_01_00_00_00_01.
- O reaches 4,5,6 before X completes a line: o_result=2, single o_result_stb pulse.
- Full board with no line (X 1,3,4,8,9; O 2,5,6,7): o_isdraw=1, o_result=0, count 9.
- O submits 0, then 0xA, then an occupied square, then 7: the first three leave the board unchanged and re-raise o_needinput 2 edges later each; 7 is accepted.
- i_busy held high for 5 cycles in O_WAIT: o_needinput stays 0, then rises 1 cycle after i_busy falls. i_validmove_stb held high for 2 cycles: only the first is consumed.
- Assert i_reset mid-game (after 4 moves), and separately pulse i_newgame in DONE: board, outputs and count return to reset values, and play restarts from START.
